mdu: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It sits beside the ALU in EX and is started by MULT/MULTU/DIV/DIVU/MTHI/MTLO. It computes one result bit per cycle and holds `busy` so the hazard logic can stall MFHI/MFLO and any new MDU instruction. `WIDTH` generalises the datapath beyond 32 bits.

---
 rtl/mdu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one result bit per clock, followed by a sign-fix cycle.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, r_sh, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;

        // Multiply adds the multiplicand into the upper half; divide trial-subtracts
        // the divisor from the remainder shifted left by the next dividend bit.
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        r_sh      = {rem_q, acc_q[WIDTH-1]};
        diff      = r_sh - {1'b0, opb_q};

        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = op[1];
                            acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            opb_d     = op[1] ? b_mag : a_mag;
                            rem_d     = '0;
                            araw_d    = a;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = op[1] & (b == '0);
                            cnt_d     = CW'(WIDTH);
                            state_d   = S_CALC;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    rem_d = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle MTHI/MTLO.
        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            araw_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            araw_q    <= araw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
